tia_hsync_ctrl: RTL
===================

Name: tia_hsync_ctrl

Overview:
- Horizontal timing controller for the TIA model.
- Divides the colour clock by 4 into 57 horizontal counts (228 colour clocks per line).
- Decodes the count into set/reset events that drive the horizontal flag latches: HSYNC, HBLANK, colour burst, RDY (WSYNC hold) and the HMOVE extended-blank latch.
- Sits between the register-strobe decoder (WSYNC/RSYNC/HMOVE) and the video output and object logic.

Parameters:
- LINE_COUNTS, 57, horizontal counts per line; the count wraps 56 -> 0.
- CNT_W, 6, width of the horizontal count.

Ports:
- clk  in  1  colour clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wsync  in  1  one-cycle strobe: pull RDY low until the next line start.
- rsync  in  1  one-cycle strobe: restart the line.
- hmove  in  1  one-cycle strobe: set the HMOVE extended-blank latch.
- hcount  out  CNT_W  current horizontal count, 0..56.
- hphase  out  2  colour clock within the count, 0..3.
- line_start  out  1  high exactly when hcount=0 and hphase=0.
- hsync  out  1  horizontal sync.
- hblank  out  1  horizontal blank.
- cburst  out  1  colour burst window.
- rdy  out  1  CPU ready; low while a WSYNC is pending.
- hmove_blank  out  1  HMOVE latch state.

Behaviour:
- All outputs are registered. Every clock is a colour clock; there is no enable.
- Reset (reset_n=0 at an edge):
  - hcount=0, hphase=0, line_start=0.
  - hblank=1, hsync=0, cburst=0, rdy=1, hmove_blank=0.
  - Reset overrides every strobe in the same cycle.
  - Reset mid-line abandons the line.
- Counting:
  - hphase increments every clock.
  - When hphase goes 3 -> 0, hcount increments; 56 -> 0 wraps.
  - Line period is 228 clocks.
- Events take effect on the edge where the counter enters (count N, phase 0). "Cycle c" means c clocks after a line start.
  - N=0: set hblank; release rdy (rdy=1).
  - N=4: set hsync.
  - N=8: clear hsync; set cburst.
  - N=12: clear cburst.
  - N=16: clear hblank if hmove_blank=0.
  - N=18: clear hblank if hmove_blank=1; clear hmove_blank.
- wsync: rdy=0 on the next edge.
  - wsync on the same edge as the count-0 release: set wins, and rdy stays low until the following line start.
- hmove: hmove_blank=1 on the next edge.
  - An hmove strobe on the same edge as the count-16 event counts as set, so hblank holds until count 18.
  - An hmove strobe on the same edge as the count-18 clear: set wins, and the latch carries into the next line.
- rsync: the next state is count 0, phase 0, with all N=0 effects applied.
  - hsync and cburst are cleared.
  - hmove_blank and a pending WSYNC are preserved, except that the N=0 rdy release still applies.
  - rsync while already at line start is idempotent.
- Strobe priority on a single edge: reset > rsync > wsync/hmove (independent of each other).
- line_start is high for one clock per line, and for the cycle after an rsync.

Decomposition:
- Shared package tia_hpkg:
  - count constants HC_SHB=0, HC_SHS=4, HC_RHS=8, HC_RCB=12, HC_RHB=16, HC_LRHB=18, HC_END=56;
  - LINE_COUNTS;
  - phase width.
- One sub-module, tia_sr_sync: a clocked set/reset flag with reset value and set-wins/reset-wins priority as parameters. It is the synchronous counterpart of the combinational SR latch, and is instantiated five times (hsync, hblank, cburst, rdy, hmove_blank).

Test Plan:
- Release reset, free-run 2 lines -> line_start at cycles 0 and 228; hsync high cycles 16..31; cburst high 32..47; hblank high 0..63, low 64..227.
- hmove strobe at cycle 10 -> hblank high 0..71, low from 72; hmove_blank clears at 72; next line hblank low again from 64.
- wsync at cycle 100 -> rdy=0 from cycle 101 to 227; rdy=1 at cycle 228.
- wsync on the edge into cycle 228 -> rdy stays 0 until cycle 456.
- rsync at cycle 20 (hsync high) -> next cycle hcount=0, hphase=0, line_start=1, hsync=0, hblank=1; the next line_start follows 228 clocks later.
- reset_n=0 for 1 cycle at cycle 40 with hmove and wsync pending -> all outputs at reset values, rdy=1, hmove_blank=0; counting resumes from 0.

Source files
------------

// File: rtl/tia_hpkg.sv
// Shared constants for the TIA horizontal timing controller: line length,
// the horizontal counts at which flag events fire, and the phase width.
package tia_hpkg;

    localparam int LINE_COUNTS = 57;
    localparam int PHASE_W     = 2;

    // Horizontal counts at which set/reset events take effect
    localparam int HC_SHB  = 0;   // set hblank, release rdy
    localparam int HC_SHS  = 4;   // set hsync
    localparam int HC_RHS  = 8;   // clear hsync, set colour burst
    localparam int HC_RCB  = 12;  // clear colour burst
    localparam int HC_RHB  = 16;  // clear hblank (no HMOVE)
    localparam int HC_LRHB = 18;  // clear hblank (HMOVE), clear HMOVE latch
    localparam int HC_END  = 56;  // last count of the line

endpackage : tia_hpkg

// File: rtl/tia_sr_sync.sv
// Clocked set/reset flag: the synchronous counterpart of the TIA's SR latches.
// SET_WINS selects which request dominates when set and clear coincide.
module tia_sr_sync #(
    parameter logic RST_VAL  = 1'b0,
    parameter logic SET_WINS = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic q
);

    logic flag_d;
    logic flag_q;

    // Next flag value from the set/clear requests and the chosen priority
    always_comb begin
        flag_d = flag_q;
        if (set && clr) begin
            flag_d = SET_WINS;
        end else if (set) begin
            flag_d = 1'b1;
        end else if (clr) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Flag register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag_q <= RST_VAL;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q = flag_q;

endmodule : tia_sr_sync

// File: rtl/tia_hsync_ctrl.sv
// TIA horizontal timing: divides the colour clock by 4 into 57 counts per
// line and turns count boundaries into set/reset events for the horizontal
// flags (HSYNC, HBLANK, colour burst, RDY and the HMOVE extended blank).
module tia_hsync_ctrl #(
    parameter int LINE_COUNTS = tia_hpkg::LINE_COUNTS,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wsync,
    input  logic             rsync,
    input  logic             hmove,
    output logic [CNT_W-1:0] hcount,
    output logic [1:0]       hphase,
    output logic             line_start,
    output logic             hsync,
    output logic             hblank,
    output logic             cburst,
    output logic             rdy,
    output logic             hmove_blank
);

    import tia_hpkg::*;

    logic [CNT_W-1:0]   hcount_d;
    logic [CNT_W-1:0]   hcount_q;
    logic [PHASE_W-1:0] hphase_d;
    logic [PHASE_W-1:0] hphase_q;
    logic               line_start_d;
    logic               line_start_q;

    logic ev_shb;
    logic ev_shs;
    logic ev_rhs;
    logic ev_rcb;
    logic ev_rhb;
    logic ev_lrhb;
    logic hmove_acc;
    logic hmove_eff;

    // Next counter position; rsync restarts the line at count 0, phase 0
    always_comb begin
        hcount_d = hcount_q;
        hphase_d = hphase_q;
        if (rsync) begin
            hcount_d = {CNT_W{1'b0}};
            hphase_d = {PHASE_W{1'b0}};
        end else if (hphase_q == 2'd3) begin
            hphase_d = 2'd0;
            if (hcount_q == CNT_W'(LINE_COUNTS - 1)) begin
                hcount_d = {CNT_W{1'b0}};
            end else begin
                hcount_d = hcount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            hphase_d = hphase_q + 2'd1;
            hcount_d = hcount_q;
        end
    end

    // Events fire on the edge that enters (count N, phase 0)
    always_comb begin
        ev_shb       = (hphase_d == 2'd0) && (hcount_d == CNT_W'(HC_SHB));
        ev_shs       = (hphase_d == 2'd0) && (hcount_d == CNT_W'(HC_SHS));
        ev_rhs       = (hphase_d == 2'd0) && (hcount_d == CNT_W'(HC_RHS));
        ev_rcb       = (hphase_d == 2'd0) && (hcount_d == CNT_W'(HC_RCB));
        ev_rhb       = (hphase_d == 2'd0) && (hcount_d == CNT_W'(HC_RHB));
        ev_lrhb      = (hphase_d == 2'd0) && (hcount_d == CNT_W'(HC_LRHB));
        line_start_d = ev_shb;
        // rsync outranks the other strobes on the same edge
        hmove_acc    = hmove && !rsync;
        // A strobe arriving with the count-16 event already extends the blank
        hmove_eff    = hmove_blank || hmove_acc;
    end

    // Counter and line-start registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcount_q     <= {CNT_W{1'b0}};
            hphase_q     <= {PHASE_W{1'b0}};
            line_start_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_d;
            hphase_q     <= hphase_d;
            line_start_q <= line_start_d;
        end
    end

    tia_sr_sync #(.RST_VAL(1'b0), .SET_WINS(1'b1)) u_hsync (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (ev_shs),
        .clr     (ev_rhs || rsync),
        .q       (hsync)
    );

    tia_sr_sync #(.RST_VAL(1'b0), .SET_WINS(1'b1)) u_cburst (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (ev_rhs),
        .clr     (ev_rcb || rsync),
        .q       (cburst)
    );

    tia_sr_sync #(.RST_VAL(1'b1), .SET_WINS(1'b1)) u_hblank (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (ev_shb),
        .clr     ((ev_rhb && !hmove_eff) || (ev_lrhb && hmove_eff)),
        .q       (hblank)
    );

    // WSYNC coinciding with the line-start release keeps the CPU halted
    tia_sr_sync #(.RST_VAL(1'b1), .SET_WINS(1'b0)) u_rdy (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (ev_shb),
        .clr     (wsync && !rsync),
        .q       (rdy)
    );

    // An HMOVE strobe on the count-18 clear carries into the next line
    tia_sr_sync #(.RST_VAL(1'b0), .SET_WINS(1'b1)) u_hmove_blank (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (hmove_acc),
        .clr     (ev_lrhb),
        .q       (hmove_blank)
    );

    assign hcount     = hcount_q;
    assign hphase     = hphase_q;
    assign line_start = line_start_q;

endmodule : tia_hsync_ctrl
